fb_dbuf_scheduler: RTL
======================

Name: fb_dbuf_scheduler

Overview:
Sequences the two-SRAM frame-buffer double buffer. Tracks producer AXI writes in flight (AW accepted, B not yet returned). Issues the buffer switch only when the back buffer is complete and fully drained: immediately for the first frame, then only on the falling edge of the display vsync. Sits between the gfx producer/fb writer, the dbuf SRAM controller's switch input and the pixel stream's enable.

Parameters:
OUTSTANDING_BITS, 4, width of the in-flight write counter (max 2^N-1 outstanding)
FRAME_BITS, 16, width of frame_count and late_count

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
prod_awvalid  input  1  producer write address valid (monitored only)
prod_awready  input  1  producer write address ready (monitored only)
prod_bvalid  input  1  producer write response valid (monitored only)
prod_bready  input  1  producer write response ready (monitored only)
prod_last  input  1  one-cycle pulse: producer has issued the final pixel of a frame
vsync  input  1  vsync from the pixel stream, clk domain
mem_switch  output  1  one-cycle pulse to the dbuf controller's switch input
prod_restart  output  1  one-cycle pulse restarting the producer on the new back buffer
disp_enable  output  1  pixel stream enable, sticky once set
outstanding  output  OUTSTANDING_BITS  current in-flight write count
frame_count  output  FRAME_BITS  completed switches, wraps
late_count  output  FRAME_BITS  vsync edges with no frame ready, saturating
err  output  1  sticky counter overflow/underflow flag

Behaviour:
- Reset (async assert, sync deassert internally not required): state=INIT_DRAW; all outputs 0; vsync_q=1.
- aw_fire = prod_awvalid & prod_awready; b_fire = prod_bvalid & prod_bready.
- outstanding: +1 on aw_fire only; -1 on b_fire only; unchanged when both or neither.
- Overflow (aw_fire only, count at max): count holds, err<=1.
- Underflow (b_fire only, count 0): count holds at 0, err<=1. err clears only on reset.
- vsync_fall = vsync_q & ~vsync, where vsync_q is vsync registered.
- States:
  - INIT_DRAW: prod_last -> INIT_DRAIN.
  - INIT_DRAIN: when outstanding==0 and no aw_fire this cycle -> SWITCH_FIRST.
  - SWITCH_FIRST: one cycle. mem_switch=1, prod_restart=1, disp_enable<=1 (registered, visible the next cycle) -> DRAWING. No vsync required.
  - DRAWING: prod_last -> DRAINING.
  - DRAINING: outstanding==0 and no aw_fire -> READY.
  - READY: vsync_fall -> SWITCH.
  - SWITCH: one cycle. mem_switch=1, prod_restart=1 -> DRAWING.
- frame_count increments, wrapping, in each SWITCH/SWITCH_FIRST cycle.
- mem_switch and prod_restart are registered outputs, high exactly one cycle.
  - Latency from vsync_fall observed in READY at cycle T: pulse at T+1.
- vsync_fall while disp_enable=1 and state is DRAWING or DRAINING: no switch; the display repeats the front buffer; late_count+1, saturating at all-ones.
- vsync_fall in the same cycle DRAINING completes counts as late. The frame then switches on the next vsync_fall.
- vsync_fall before disp_enable: ignored, late_count unchanged.
- prod_last outside INIT_DRAW/DRAWING: ignored.
- prod_last coincident with aw_fire: drain waits for that write's B as well.
- Reset asserted mid-frame: immediate return to INIT_DRAW, disp_enable drops, counters clear. The producer is expected to be reset by the same rst_n.

Decomposition:
- Shared package fb_dbuf_pkg: state enum fb_dbuf_state_t {INIT_DRAW, INIT_DRAIN, SWITCH_FIRST, DRAWING, DRAINING, READY, SWITCH}.
- One sub-module: axi_wr_inflight_counter. Up/down counter with simultaneous-event handling, overflow/underflow sticky err, parameterised width. Reusable by other AXI writers.
- Edge detection is done inline (single flop).

Test Plan:
- Three aw_fire, prod_last, then Bs returned at cycles +5/+6/+7 -> mem_switch pulses once, the cycle after outstanding reaches 0; disp_enable=1 the following cycle; frame_count=1.
- In READY, drive vsync 1->0 at cycle T -> mem_switch and prod_restart high at T+1 only; state DRAWING; frame_count=2.
- After disp_enable, hold outstanding=2 across two vsync falls -> no mem_switch, late_count=2. After drain, the next vsync fall switches.
- Simultaneous aw_fire and b_fire with outstanding=3 -> stays 3. b_fire at 0 -> stays 0, err=1. Sixteen aw_fire with no B at width 4 -> count 15, err=1.
- Assert rst_n low mid-DRAINING with outstanding=5 -> asynchronously all outputs 0, state INIT_DRAW; vsync falls ignored until the first frame completes again.
- vsync_fall on the same cycle outstanding hits 0 in DRAINING -> late_count+1, no pulse; switch on the next vsync_fall.

Source files
------------

// File: rtl/fb_dbuf_pkg.sv
// Shared types for the frame-buffer double-buffer scheduler.
package fb_dbuf_pkg;

  typedef enum logic [2:0] {
    INIT_DRAW    = 3'd0,
    INIT_DRAIN   = 3'd1,
    SWITCH_FIRST = 3'd2,
    DRAWING      = 3'd3,
    DRAINING     = 3'd4,
    READY        = 3'd5,
    SWITCH       = 3'd6
  } fb_dbuf_state_t;

endpackage

// File: rtl/axi_wr_inflight_counter.sv
// Counts AXI writes in flight (AW accepted, B not yet returned).
// Simultaneous AW and B cancel out. Overflow and underflow hold the count
// and raise a sticky error that only reset clears.
module axi_wr_inflight_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Next count and error from the two fire events.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc_i && !dec_i) begin
      if (count_q == CNT_MAX) err_d = 1'b1;
      else                    count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) err_d = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  // Count and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/fb_dbuf_scheduler.sv
// Double-buffer switch scheduler between the gfx producer, the dbuf SRAM
// controller and the pixel stream.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   INIT_DRAW    | first frame being drawn, display disabled
//   INIT_DRAIN   | first frame issued, waiting for all B responses
//   SWITCH_FIRST | first switch pulse, no vsync needed; enables display
//   DRAWING      | producer drawing into the back buffer
//   DRAINING     | frame issued, waiting for all B responses
//   READY        | back buffer complete, waiting for vsync falling edge
//   SWITCH       | switch pulse
module fb_dbuf_scheduler
  import fb_dbuf_pkg::*;
#(
  parameter int unsigned OUTSTANDING_BITS = 4,
  parameter int unsigned FRAME_BITS       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        prod_awvalid,
  input  logic                        prod_awready,
  input  logic                        prod_bvalid,
  input  logic                        prod_bready,
  input  logic                        prod_last,
  input  logic                        vsync,
  output logic                        mem_switch,
  output logic                        prod_restart,
  output logic                        disp_enable,
  output logic [OUTSTANDING_BITS-1:0] outstanding,
  output logic [FRAME_BITS-1:0]       frame_count,
  output logic [FRAME_BITS-1:0]       late_count,
  output logic                        err
);

  localparam logic [FRAME_BITS-1:0] LATE_MAX = '1;

  fb_dbuf_state_t        state_q;
  logic                  vsync_q;
  logic                  mem_switch_q;
  logic                  prod_restart_q;
  logic                  disp_enable_q;
  logic [FRAME_BITS-1:0] frame_count_q;
  logic [FRAME_BITS-1:0] late_count_q;

  logic aw_fire, b_fire, vsync_fall, drained, late_evt;

  assign aw_fire    = prod_awvalid & prod_awready;
  assign b_fire     = prod_bvalid & prod_bready;
  assign vsync_fall = vsync_q & ~vsync;
  // A write accepted this cycle still needs its B, so it blocks the drain.
  assign drained    = (outstanding == '0) && !aw_fire;
  // Display is live but the back buffer is not ready: front buffer repeats.
  assign late_evt   = vsync_fall && disp_enable_q &&
                      ((state_q == DRAWING) || (state_q == DRAINING));

  axi_wr_inflight_counter #(
    .WIDTH (OUTSTANDING_BITS)
  ) u_inflight (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (aw_fire),
    .dec_i   (b_fire),
    .count_o (outstanding),
    .err_o   (err)
  );

  // Sequencing FSM with registered pulse outputs and frame/late counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT_DRAW;
      vsync_q        <= 1'b1;
      mem_switch_q   <= 1'b0;
      prod_restart_q <= 1'b0;
      disp_enable_q  <= 1'b0;
      frame_count_q  <= '0;
      late_count_q   <= '0;
    end else begin
      vsync_q        <= vsync;
      mem_switch_q   <= 1'b0;
      prod_restart_q <= 1'b0;

      if (late_evt && (late_count_q != LATE_MAX))
        late_count_q <= late_count_q + 1'b1;

      case (state_q)
        INIT_DRAW: begin
          if (prod_last) state_q <= INIT_DRAIN;
        end
        INIT_DRAIN: begin
          if (drained) begin
            state_q        <= SWITCH_FIRST;
            mem_switch_q   <= 1'b1;
            prod_restart_q <= 1'b1;
          end
        end
        SWITCH_FIRST: begin
          disp_enable_q <= 1'b1;
          frame_count_q <= frame_count_q + 1'b1;
          state_q       <= DRAWING;
        end
        DRAWING: begin
          if (prod_last) state_q <= DRAINING;
        end
        DRAINING: begin
          if (drained) state_q <= READY;
        end
        READY: begin
          if (vsync_fall) begin
            state_q        <= SWITCH;
            mem_switch_q   <= 1'b1;
            prod_restart_q <= 1'b1;
          end
        end
        SWITCH: begin
          frame_count_q <= frame_count_q + 1'b1;
          state_q       <= DRAWING;
        end
        default: state_q <= INIT_DRAW;
      endcase
    end
  end

  assign mem_switch   = mem_switch_q;
  assign prod_restart = prod_restart_q;
  assign disp_enable  = disp_enable_q;
  assign frame_count  = frame_count_q;
  assign late_count   = late_count_q;

endmodule
